// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch FSM top and its timeout counter.
package fetch_pkg;

    localparam int          DEF_TIMEOUT_CYC = 64;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [1:0]  ALIGN_MASK      = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating cycle counter for a pending memory request; flags the cycle
// in which the TIMEOUT_CYC-th consecutive enabled cycle completes.
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires on the edge where the count would reach TIMEOUT_CYC.
    assign expired = enable && !clear && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: takes a PC, issues one imem req/ack transaction and presents
// the returned word to decode; handles misalignment, timeout and flush.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INSTR_W     = 32,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               misalign_err,
    output logic               timeout_err
);

    fetch_state_e       r_state, w_state_n;
    logic [ADDR_W-1:0]  r_pc_q, w_pc_q_n;
    logic               r_imem_req, w_imem_req_n;
    logic [ADDR_W-1:0]  r_imem_addr, w_imem_addr_n;
    logic [INSTR_W-1:0] r_instr_out, w_instr_out_n;
    logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_n;
    logic               r_instr_valid, w_instr_valid_n;
    logic               r_misalign_err, w_misalign_err_n;
    logic               r_timeout_err, w_timeout_err_n;
    logic               r_drop, w_drop_n;

    logic w_expired;
    logic w_misaligned;
    logic w_in_req;

    assign w_in_req     = (r_state == REQ);
    assign w_misaligned = (pc_in[1:0] & ALIGN_MASK) != 2'b00;

    fetch_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (!w_in_req),
        .enable  (w_in_req),
        .expired (w_expired)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_n        = r_state;
        w_pc_q_n         = r_pc_q;
        w_imem_req_n     = r_imem_req;
        w_imem_addr_n    = r_imem_addr;
        w_instr_out_n    = r_instr_out;
        w_instr_pc_n     = r_instr_pc;
        w_instr_valid_n  = r_instr_valid;
        w_misalign_err_n = r_misalign_err;
        w_timeout_err_n  = r_timeout_err;
        w_drop_n         = r_drop;

        unique case (r_state)
            IDLE: begin
                if (pc_valid) begin
                    w_pc_q_n = pc_in;
                    if (w_misaligned) begin
                        w_misalign_err_n = 1'b1;
                        w_state_n        = ERR;
                    end else begin
                        w_imem_req_n  = 1'b1;
                        w_imem_addr_n = pc_in;
                        w_state_n     = REQ;
                    end
                end
            end
            REQ: begin
                // Request stays up until ack or timeout; flush only marks the response as dead.
                if (imem_ack) begin
                    w_imem_req_n = 1'b0;
                    w_drop_n     = 1'b0;
                    if (r_drop || flush) begin
                        w_state_n = IDLE;
                    end else begin
                        w_instr_out_n   = imem_rdata;
                        w_instr_pc_n    = r_pc_q;
                        w_instr_valid_n = 1'b1;
                        w_state_n       = HOLD;
                    end
                end else if (w_expired) begin
                    w_imem_req_n    = 1'b0;
                    w_timeout_err_n = 1'b1;
                    w_drop_n        = 1'b0;
                    w_state_n       = ERR;
                end else if (flush) begin
                    w_drop_n = 1'b1;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    w_instr_valid_n = 1'b0;
                    w_state_n       = IDLE;
                end
            end
            ERR: begin
                if (flush) begin
                    w_misalign_err_n = 1'b0;
                    w_timeout_err_n  = 1'b0;
                    w_state_n        = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // NOTE: no storage arrays here, so every register is reset; the async reset also drops imem_req mid-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pc_q         <= '0;
            r_imem_req     <= 1'b0;
            r_imem_addr    <= '0;
            r_instr_out    <= INSTR_W'(NOP_INSTR);
            r_instr_pc     <= '0;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_drop         <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_pc_q         <= w_pc_q_n;
            r_imem_req     <= w_imem_req_n;
            r_imem_addr    <= w_imem_addr_n;
            r_instr_out    <= w_instr_out_n;
            r_instr_pc     <= w_instr_pc_n;
            r_instr_valid  <= w_instr_valid_n;
            r_misalign_err <= w_misalign_err_n;
            r_timeout_err  <= w_timeout_err_n;
            r_drop         <= w_drop_n;
        end
    end

    assign pc_ready     = (r_state == IDLE);
    assign imem_req     = r_imem_req;
    assign imem_addr    = r_imem_addr;
    assign instr_out    = r_instr_out;
    assign instr_pc     = r_instr_pc;
    assign instr_valid  = r_instr_valid;
    assign misalign_err = r_misalign_err;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; delivered instructions are checked
// by a monitor against a scoreboard queue filled by the stimulus.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misalign_err;
    logic        timeout_err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    instr_fetch_unit #(
        .ADDR_W      (32),
        .INSTR_W     (32),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    // Monitor: each new presentation of instr_valid must match the next expected entry.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_instr_valid", 64'(instr_out), 64'hxxxx);
                end else begin
                    e = sb_q.pop_front();
                    check("mon_instr_out", 64'(instr_out), 64'(e.instr));
                    check("mon_instr_pc", 64'(instr_pc), 64'(e.pc));
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok_a;
        logic        ok_b;
        logic [31:0] held_instr;
        logic [31:0] held_pc;

        reset       = 1'b1;
        pc_in       = '0;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        #1;
        check("rst_pc_ready", 64'(pc_ready), 64'd1);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_instr_out", 64'(instr_out), 64'(NOP));
        check("rst_instr_pc", 64'(instr_pc), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_errs", 64'({misalign_err, timeout_err}), 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // 1: zero-wait fetch at PC 0
        pc_in    = 32'h0000_0000;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("t1_imem_req", 64'(imem_req), 64'd1);
        check("t1_imem_addr", 64'(imem_addr), 64'd0);
        check("t1_pc_ready", 64'(pc_ready), 64'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        push_exp(32'h0050_0093, 32'h0000_0000);
        tick();
        imem_ack = 1'b0;
        check("t1_instr_valid", 64'(instr_valid), 64'd1);
        check("t1_req_dropped", 64'(imem_req), 64'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t1_valid_cleared", 64'(instr_valid), 64'd0);
        check("t1_pc_ready", 64'(pc_ready), 64'd1);

        // 2: misaligned PC
        pc_in    = 32'h0000_0006;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("t2_misalign_err", 64'(misalign_err), 64'd1);
        check("t2_pc_ready", 64'(pc_ready), 64'd0);
        ok_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (imem_req !== 1'b0) ok_a = 1'b0;
            tick();
        end
        check("t2_no_req", 64'(ok_a && (imem_req === 1'b0)), 64'd1);
        check("t2_err_sticky", 64'(misalign_err), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t2_err_cleared", 64'(misalign_err), 64'd0);
        check("t2_pc_ready", 64'(pc_ready), 64'd1);

        // 3a: no ack for 64 cycles -> timeout
        pc_in    = 32'h0000_0010;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        ok_a = 1'b1;
        ok_b = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) ok_a = 1'b0;
            if (timeout_err !== 1'b0) ok_b = 1'b0;
        end
        check("t3_req_held_63", 64'(ok_a), 64'd1);
        check("t3_no_early_timeout", 64'(ok_b), 64'd1);
        tick();
        check("t3_timeout_err", 64'(timeout_err), 64'd1);
        check("t3_req_dropped", 64'(imem_req), 64'd0);
        check("t3_pc_ready", 64'(pc_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_err_cleared", 64'(timeout_err), 64'd0);

        // 3b: ack in cycle 63 -> normal capture
        pc_in    = 32'h0000_0010;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        for (int i = 1; i <= 62; i++) tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h00C0_0193;
        push_exp(32'h00C0_0193, 32'h0000_0010);
        tick();
        imem_ack = 1'b0;
        check("t3b_no_timeout", 64'(timeout_err), 64'd0);
        check("t3b_instr_valid", 64'(instr_valid), 64'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // 4: flush two cycles into REQ, ack on cycle 5 is discarded
        pc_in    = 32'h0000_0020;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_req_held", 64'(imem_req), 64'd1);
        check("t4_addr_held", 64'(imem_addr), 64'h20);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("t4_instr_valid", 64'(instr_valid), 64'd0);
        check("t4_instr_out_kept", 64'(instr_out), 64'h00C0_0193);
        check("t4_pc_ready", 64'(pc_ready), 64'd1);
        check("t4_req_dropped", 64'(imem_req), 64'd0);

        // 4b: flush together with ack discards the data
        pc_in    = 32'h0000_0024;
        pc_valid = 1'b1;
        tick();
        pc_valid   = 1'b0;
        imem_ack   = 1'b1;
        flush      = 1'b1;
        imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        flush    = 1'b0;
        check("t4b_instr_valid", 64'(instr_valid), 64'd0);
        check("t4b_pc_ready", 64'(pc_ready), 64'd1);
        check("t4b_instr_out_kept", 64'(instr_out), 64'h00C0_0193);

        // 5: long HOLD, then flush with instr_ready
        pc_in    = 32'h0000_0030;
        pc_valid = 1'b1;
        tick();
        pc_valid   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0113;
        push_exp(32'h00A0_0113, 32'h0000_0030);
        tick();
        imem_ack   = 1'b0;
        held_instr = 32'h00A0_0113;
        held_pc    = 32'h0000_0030;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_instr", 64'(instr_out), 64'(held_instr));
            check("t5_hold_pc", 64'(instr_pc), 64'(held_pc));
            check("t5_hold_valid", 64'(instr_valid), 64'd1);
        end
        flush       = 1'b1;
        instr_ready = 1'b1;
        tick();
        flush       = 1'b0;
        instr_ready = 1'b0;
        check("t5_valid_cleared", 64'(instr_valid), 64'd0);
        check("t5_pc_ready", 64'(pc_ready), 64'd1);

        // 6: async reset mid-REQ
        pc_in    = 32'h0000_0040;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("t6_req_up", 64'(imem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_req", 64'(imem_req), 64'd0);
        check("t6_rst_instr_out", 64'(instr_out), 64'(NOP));
        check("t6_rst_pc_ready", 64'(pc_ready), 64'd1);
        tick();
        reset    = 1'b0;
        pc_in    = 32'h0000_0044;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("t6_req_after", 64'(imem_req), 64'd1);
        check("t6_addr_after", 64'(imem_addr), 64'h44);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        push_exp(32'h1234_5678, 32'h0000_0044);
        tick();
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
